fetch_sequencer: RTL

Sequences the program-counter register and the instruction-memory request for the fetch stage of the pipelined CPU. Each cycle it decides whether the PC advances, holds or is redirected, driving PC_WEN and pc_input on the PC register from its pc_output. It holds a redirect that arrives during an outstanding instruction access until that access completes. It also stops fetch permanently on halt.

---
 rtl/fetch_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//    Sequences the program counter and the instruction-memory request for the
//    fetch stage. Each cycle it decides whether the PC advances, holds or is
//    redirected. It drives pc_wen/pc_next into the PC register and reads back
//    pc_cur. A redirect that arrives while an instruction access is still
//    outstanding is parked until that access completes. A committed halt stops
//    fetch permanently, until reset.
//
// Parameters:
//    ADDR_W   width of the PC and of the branch/jump targets
//    PC_STEP  sequential PC increment in bytes
//
// Ports:
//    CLK, nRST      clock; asynchronous active-low reset
//    pc_cur         current PC (PC register output)
//    pc_wen         PC register write enable
//    pc_next        PC register next value (pc_cur + PC_STEP when not writing)
//    iREN, iaddr    instruction read request and address (iaddr = pc_cur)
//    ihit           instruction access completes this cycle
//    stall_in       hazard-unit stall of IF/ID
//    br_taken/br_target     resolved taken branch and its target
//    jmp_valid/jmp_target   jump / jr redirect and its target
//    halt           halt instruction committed
//    fetch_valid    imem word is valid for IF/ID this cycle
//    fetch_pc       PC of the fetched word (pc_cur)
//    halted         fetch has stopped
//
// Optional build macro:
//    FETCH_PERF_EN  adds fetch_cnt[31:0] (cycles with fetch_valid) and
//                   squash_cnt[31:0] (cycles where a completed access is
//                   discarded by a redirect). Both wrap and freeze once halted.
//
// All outputs are combinational from the state register and the inputs, so
// the PC update takes effect in the same cycle the access completes.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter int ADDR_W  = 32,
   parameter int PC_STEP = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic              pc_wen,
   output logic [ADDR_W-1:0] pc_next,
   output logic              iREN,
   output logic [ADDR_W-1:0] iaddr,
   input  logic              ihit,
   input  logic              stall_in,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              jmp_valid,
   input  logic [ADDR_W-1:0] jmp_target,
   input  logic              halt,
   output logic              fetch_valid,
   output logic [ADDR_W-1:0] fetch_pc,
`ifdef FETCH_PERF_EN
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       squash_cnt,
`endif
   output logic              halted
);

   typedef enum logic [1:0] {
      FETCH      = 2'd0,
      REDIR_WAIT = 2'd1,
      HALTED     = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [ADDR_W-1:0]   pend_tgt_r;
   logic [ADDR_W-1:0]   pend_tgt_nxt_s;

   logic                redir_s;
   logic [ADDR_W-1:0]   redir_tgt_s;
   logic [ADDR_W-1:0]   pc_inc_s;

   // Sequential increment wraps silently at 2^ADDR_W.
   assign pc_inc_s = pc_cur + ADDR_W'(PC_STEP);

   // Redirect source select: a resolved branch is older than a jump in the
   // pipeline, so it wins when both fire together.
   always_comb begin
      redir_s     = br_taken | jmp_valid;
      redir_tgt_s = jmp_target;
      if (br_taken) begin
         redir_tgt_s = br_target;
      end else begin
         redir_tgt_s = jmp_target;
      end
   end

   // The fetch address is always the architectural PC.
   assign iaddr    = pc_cur;
   assign fetch_pc = pc_cur;

   // Next-state and output decode. Halt is checked first in every live state
   // so that nothing is written to the PC in the cycle the halt commits.
   always_comb begin
      state_nxt_s    = state_r;
      pend_tgt_nxt_s = pend_tgt_r;
      pc_wen         = 1'b0;
      pc_next        = pc_inc_s;
      iREN           = 1'b1;
      fetch_valid    = 1'b0;
      halted         = 1'b0;

      case (state_r)
         FETCH: begin
            if (halt) begin
               state_nxt_s = HALTED;
            end else if (redir_s) begin
               if (ihit) begin
                  // Access done: squash the word and steer the PC now.
                  pc_wen  = 1'b1;
                  pc_next = redir_tgt_s;
               end else begin
                  // Access still in flight: park the target and wait for it,
                  // otherwise the late ihit would be taken for the new PC.
                  pend_tgt_nxt_s = redir_tgt_s;
                  state_nxt_s    = REDIR_WAIT;
               end
            end else if (ihit && !stall_in) begin
               pc_wen      = 1'b1;
               fetch_valid = 1'b1;
            end else begin
               // Either waiting on memory or stalled: PC holds and the same
               // address is requested again.
               pc_wen = 1'b0;
            end
         end

         REDIR_WAIT: begin
            if (halt) begin
               state_nxt_s = HALTED;
            end else begin
               // Younger redirects replace the parked one (last wins).
               if (redir_s) begin
                  pend_tgt_nxt_s = redir_tgt_s;
               end else begin
                  pend_tgt_nxt_s = pend_tgt_r;
               end
               // The completing word belongs to the abandoned path; stall_in
               // is irrelevant because nothing is handed to IF/ID.
               if (ihit) begin
                  pc_wen      = 1'b1;
                  state_nxt_s = FETCH;
                  if (redir_s) begin
                     pc_next = redir_tgt_s;
                  end else begin
                     pc_next = pend_tgt_r;
                  end
               end else begin
                  pc_wen = 1'b0;
               end
            end
         end

         HALTED: begin
            // Any outstanding access is abandoned; sticky until reset.
            iREN   = 1'b0;
            halted = 1'b1;
         end

         default: begin
            // Unreachable encoding: recover to a known fetch state.
            state_nxt_s    = FETCH;
            pend_tgt_nxt_s = {ADDR_W{1'b0}};
         end
      endcase
   end

   // State and parked redirect target registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r    <= FETCH;
         pend_tgt_r <= {ADDR_W{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         pend_tgt_r <= pend_tgt_nxt_s;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_r;
   logic [31:0] squash_cnt_r;
   logic        squash_s;

   // A discard is a completed access that writes the PC without delivering
   // the word. In HALTED both fetch_valid and pc_wen are low, so the counters
   // freeze there without an explicit state check.
   assign squash_s = ihit & pc_wen & ~fetch_valid;

   // Performance counters, wrapping at 2^32.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fetch_cnt_r  <= 32'd0;
         squash_cnt_r <= 32'd0;
      end else begin
         if (fetch_valid) begin
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
         end
         if (squash_s) begin
            squash_cnt_r <= squash_cnt_r + 32'd1;
         end
      end
   end

   assign fetch_cnt  = fetch_cnt_r;
   assign squash_cnt = squash_cnt_r;
`endif

endmodule
